// File: rtl/hbif_pkg.sv
// hbif_pkg: shared types and defaults for the host-bus-interface UART path
package hbif_pkg;
    localparam int HBIF_DATA_BITS    = 8;
    localparam int HBIF_CLKS_PER_BIT = 87;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_e;
endpackage

// File: rtl/hbif_sync2.sv
// hbif_sync2: two-flop synchroniser for asynchronous inputs with selectable reset value
module hbif_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta <= RST_VAL;
            q_o  <= RST_VAL;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end
endmodule

// File: rtl/hbif_uart_rx.sv
// hbif_uart_rx: 8N1 UART deframer feeding a valid/ready byte stream,
// with one-cycle framing-error and overrun pulses.
module hbif_uart_rx
    import hbif_pkg::*;
#(
    parameter int CLKS_PER_BIT = HBIF_CLKS_PER_BIT,
    parameter int DATA_BITS    = HBIF_DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("hbif_uart_rx: CLKS_PER_BIT must be >= 4");
    end

    uart_rx_state_e        state, state_nxt;
    logic [CW-1:0]         cyc;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic rxs, en_q, en_rise, active, half_hit, bit_hit, last_bit;
    logic stop_hit, load, ovr, ferr;

    hbif_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (rx_i),
        .q_o   (rxs)
    );

    assign en_rise  = en_i & ~en_q;
    assign active   = state inside {ST_START, ST_DATA, ST_STOP};
    assign half_hit = cyc == CW'(CLKS_PER_BIT / 2 - 1);
    assign bit_hit  = cyc == CW'(CLKS_PER_BIT - 1);
    assign last_bit = bit_cnt == BW'(DATA_BITS - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // A rising enable parks in WAIT_HIGH so a line already low cannot start a frame
    always_comb begin
        state_nxt = state;
        if (!en_i) state_nxt = ST_IDLE;
        else if (en_rise) state_nxt = ST_WAIT_HIGH;
        else begin
            case (state)
                ST_IDLE:  if (!rxs) state_nxt = ST_START;
                ST_START: if (half_hit) state_nxt = rxs ? ST_IDLE : ST_DATA;
                ST_DATA:  if (bit_hit && last_bit) state_nxt = ST_STOP;
                ST_STOP:  if (bit_hit) state_nxt = rxs ? ST_IDLE : ST_WAIT_HIGH;
                default:  if (rxs) state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stop_hit = state == ST_STOP && bit_hit && en_i;
        load     = stop_hit && rxs && (!valid_o || ready_i);
        ovr      = stop_hit && rxs && valid_o && !ready_i;
        ferr     = stop_hit && !rxs;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q        <= 1'b1;
            cyc         <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            en_q        <= en_i;
            cyc         <= (active && state_nxt == state && !bit_hit) ? cyc + CW'(1) : '0;
            bit_cnt     <= (state == ST_DATA && state_nxt == ST_DATA) ? bit_cnt + BW'(bit_hit) : '0;
            if (state == ST_DATA && bit_hit) shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (load) data_o <= shreg;
            valid_o     <= load || (valid_o && !ready_i);
            frame_err_o <= ferr;
            overrun_o   <= ovr;
        end
    end
endmodule

// File: tb/tb_hbif_uart_rx.sv
// tb_hbif_uart_rx: directed frames against hbif_uart_rx at 16 clocks per bit
module tb_hbif_uart_rx;
    localparam int CPB = 16;

    logic       clk_i = 1'b0, rst_ni = 1'b0, en_i = 1'b1, rx_i = 1'b1, ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o, frame_err_o, overrun_o;
    int         total = 0, bad = 0, cyc_n = 0;
    int         n_vhi = 0, n_ferr = 0, n_ovr = 0, rise_cyc = -1;
    logic       prev_v = 1'b0;
    logic [7:0] acc[$];

    always #5 clk_i = ~clk_i;

    hbif_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    always @(posedge clk_i) cyc_n++;

    // Stream monitor, sampled mid-low-phase
    always @(negedge clk_i) begin
        #1;
        if (valid_o && ready_i) acc.push_back(data_o);
        if (valid_o) n_vhi++;
        if (valid_o && !prev_v) rise_cyc = cyc_n;
        prev_v = valid_o;
        n_ferr += int'(frame_err_o);
        n_ovr  += int'(overrun_o);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            idle(CPB);
        end
        rx_i = stop;
        idle(CPB);
        rx_i = 1'b1;
    endtask

    task automatic clr();
        n_vhi = 0;
        n_ferr = 0;
        n_ovr = 0;
        rise_cyc = -1;
        acc.delete();
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (acc.size() > i) ? {24'd0, acc[i]} : 32'hdead;
    endfunction

    initial begin
        int t0;
        idle(3);
        #2;
        chk("rst_data", data_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_ovr", overrun_o, 0);
        rst_ni = 1'b1;
        idle(5);

        clr();
        t0 = cyc_n;
        send(8'h55, 1'b1);
        idle(40);
        chk("t1_count", acc.size(), 1);
        chk("t1_data", acc_at(0), 8'h55);
        chk("t1_latency", (rise_cyc - t0 >= 154 && rise_cyc - t0 <= 156), 1);
        chk("t1_valid_cycles", n_vhi, 1);
        chk("t1_ferr", n_ferr, 0);
        chk("t1_ovr", n_ovr, 0);

        clr();
        rx_i = 1'b0;
        idle(4);
        rx_i = 1'b1;
        idle(60);
        chk("t2_no_valid", n_vhi, 0);
        chk("t2_no_ferr", n_ferr, 0);
        chk("t2_data_hold", data_o, 8'h55);

        clr();
        send(8'hA3, 1'b0);
        rx_i = 1'b0;
        idle(40);
        rx_i = 1'b1;
        idle(40);
        send(8'h3C, 1'b1);
        idle(40);
        chk("t3_ferr_once", n_ferr, 1);
        chk("t3_count", acc.size(), 1);
        chk("t3_data", acc_at(0), 8'h3C);

        clr();
        ready_i = 1'b0;
        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        idle(20);
        chk("t4_held_data", data_o, 8'h12);
        chk("t4_held_valid", valid_o, 1);
        chk("t4_ovr_once", n_ovr, 1);
        chk("t4_no_accept", acc.size(), 0);
        fork
            send(8'h56, 1'b1);
            begin
                idle(154);
                ready_i = 1'b1;
                idle(1);
                #2;
                chk("t4_load_valid", valid_o, 1);
                chk("t4_load_data", data_o, 8'h56);
            end
        join
        idle(20);
        chk("t4_acc_count", acc.size(), 2);
        chk("t4_acc0", acc_at(0), 8'h12);
        chk("t4_acc1", acc_at(1), 8'h56);
        chk("t4_ovr_still_one", n_ovr, 1);

        clr();
        fork
            send(8'hFF, 1'b1);
            begin
                idle(60);
                rst_ni = 1'b0;
                #2;
                chk("t5_rst_data", data_o, 0);
                chk("t5_rst_valid", valid_o, 0);
                chk("t5_rst_ferr", frame_err_o, 0);
                chk("t5_rst_ovr", overrun_o, 0);
                idle(5);
                rst_ni = 1'b1;
            end
        join
        idle(20);
        send(8'h81, 1'b1);
        idle(40);
        chk("t5_count", acc.size(), 1);
        chk("t5_data", acc_at(0), 8'h81);
        chk("t5_ferr", n_ferr, 0);

        clr();
        fork
            send(8'h77, 1'b1);
            begin
                idle(130);
                en_i = 1'b0;
                idle(10);
                en_i = 1'b1;
            end
        join
        idle(20);
        chk("t6_no_valid", n_vhi, 0);
        chk("t6_no_ferr", n_ferr, 0);
        send(8'h99, 1'b1);
        idle(40);
        chk("t6_count", acc.size(), 1);
        chk("t6_data", acc_at(0), 8'h99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
